cordic_cos_scheduler: RTL and testbench
=======================================

Name: cordic_cos_scheduler

Overview:
Shares one fixed-latency pipelined CORDIC cosine unit between NUM_REQ requesters. A round-robin arbiter issues at most one angle per cycle into the pipe, and a shadow valid/tag pipeline tracks each in-flight operation. Each result is returned to its originating requester with a valid/ready handshake. Response backpressure stalls the whole pipe through the CORDIC's shared enable input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 22, angle/cosine width, signed Q2.20 (1.0 = 22'h100000)
PIPE_LATENCY, 17, enabled clock edges from angle sample to matching cordic_cos
TAG_W, 2, requester id width, equal to clog2(NUM_REQ)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears scheduler state and is forwarded to the CORDIC
req_valid  in  NUM_REQ  per-requester request valid
req_angle  in  NUM_REQ*DATA_W  packed angles; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant, asserted in the cycle the request is accepted
cordic_enable  out  1  CORDIC enable: the pipe advances and samples cordic_angle when high, holds when low
cordic_reset  out  1  drives the CORDIC reset; equals reset
cordic_angle  out  DATA_W  angle presented to the CORDIC
cordic_cos  in  DATA_W  CORDIC cosine output
rsp_valid  out  1  result available
rsp_tag  out  TAG_W  requester id of the result
rsp_cos  out  DATA_W  cosine result, equal to cordic_cos
rsp_ready  in  1  consumer accepts the result
in_flight  out  clog2(PIPE_LATENCY+1)  count of valid entries in the pipe
idle  out  1  high when in_flight is 0 and no req_valid is set

Behaviour:
- Reset, synchronous and active-high:
  - shadow valid bits cleared, round-robin pointer = 0, in_flight = 0.
  - rsp_valid = 0, req_ready = 0, cordic_enable = 0, cordic_angle = 0.
  - All in-flight operations are dropped. Requests pending at reset are not granted that cycle.
- advance = ~reset & ~(tail_valid & ~rsp_ready). This is combinational; cordic_enable = advance.
- Arbitration, combinational:
  - When advance is high, grant the first requester with req_valid set, searching from ptr upward modulo NUM_REQ.
  - Set req_ready for that requester only.
  - cordic_angle = the granted requester's angle, or 0 when there is no grant.
- Pointer update: on a granted cycle ptr <= granted index + 1 (wraps at NUM_REQ). Otherwise ptr holds.
- Shadow pipe: PIPE_LATENCY stages of {valid, tag}.
  - On advance, stage 0 loads {grant_any, grant_idx} and every other stage shifts by one.
  - When advance is low, all stages hold, in lockstep with the stalled CORDIC.
- Response path:
  - rsp_valid = tail_valid, rsp_tag = tail tag, rsp_cos = cordic_cos.
  - These stay stable while rsp_ready is low, because neither pipe moves.
- Latency: a grant on enabled edge k produces its response at the tail after PIPE_LATENCY enabled edges.
  - The minimum, unstalled latency is exactly PIPE_LATENCY cycles.
- Bubbles: an advance with no grant inserts valid = 0. Bubbles never produce rsp_valid.
- Stall: when the tail is valid and rsp_ready is low, advance = 0. No grants occur and all req_ready are 0.
- Simultaneous accept and issue: when the tail is valid, rsp_ready = 1 and a request is pending:
  - the response retires and the new grant enters stage 0 on the same edge;
  - in_flight is unchanged.
- in_flight update on an advancing edge: +1 if a grant, −1 if the tail is valid. It holds when not advancing.
- Requester i must hold req_angle stable while req_valid[i] is high and req_ready[i] is low.
- Dropping req_valid before a grant is legal; the request is simply withdrawn.
- Angle range: inputs must lie within ±1.74 rad. No checking or range reduction is done in this block.

Decomposition:
- Shared package cordic_pkg: DATA_W, PIPE_LATENCY, Q2.20 constants ONE = 22'h100000 and PI_4 = 22'h0C90FD, and a shadow-entry struct {valid, tag}.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant with advance gating, giving a one-hot output and an index output.

Test Plan:
- Single request, angle 0 on requester 2, rsp_ready = 1:
  - req_ready[2] is high for 1 cycle;
  - rsp_valid appears exactly 17 cycles later with rsp_tag = 2 and rsp_cos = 22'h100000 ±8 LSB.
- All 4 requesters held valid continuously, each with PI_4:
  - grants run 0,1,2,3,0,... one per cycle;
  - responses arrive back-to-back in the same tag order with rsp_cos = 22'h0B504F ±8.
- Backpressure: rsp_ready low for 5 cycles while the tail is valid:
  - cordic_enable = 0 and req_ready = 0 throughout;
  - rsp_cos and rsp_tag are stable;
  - no responses are lost or duplicated after release, checked against a scoreboard.
- Simultaneous retire and issue with rsp_ready = 1 under full load:
  - in_flight stays at 17;
  - every requester gets a grant within 4 cycles (no starvation).
- Reset asserted with 10 operations in flight:
  - the next cycle shows rsp_valid = 0, in_flight = 0 and ptr = 0;
  - no stale responses appear afterwards;
  - a fresh request completes normally with latency 17.
- Sparse requests spaced 3 cycles apart:
  - bubbles produce no rsp_valid;
  - idle = 1 only when the pipe is empty and there are no requests.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared widths, Q2.20 constants and the shadow-pipe entry
// used by the shared CORDIC cosine scheduler.
package cordic_pkg;

  localparam int DATA_W       = 22;
  localparam int PIPE_LATENCY = 17;
  localparam int TAG_W        = 2;

  localparam logic [DATA_W-1:0] ONE  = 22'h100000;
  localparam logic [DATA_W-1:0] PI_4 = 22'h0C90FD;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant searching upward from ptr, gated by en;
// one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j = IDX_W'((int'(ptr) + i) % N);
      if (en && !any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_cos_scheduler.sv
// Shares one pipelined CORDIC cosine unit between requesters,
// tracking each in-flight op with a shadow valid/tag pipe.
module cordic_cos_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = cordic_pkg::DATA_W,
  parameter int PIPE_LATENCY = cordic_pkg::PIPE_LATENCY,
  parameter int TAG_W        = cordic_pkg::TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_angle,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cordic_enable,
  output logic                        cordic_reset,
  output logic [DATA_W-1:0]           cordic_angle,
  input  logic [DATA_W-1:0]           cordic_cos,
  output logic                        rsp_valid,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [DATA_W-1:0]           rsp_cos,
  input  logic                        rsp_ready,
  output logic [$clog2(PIPE_LATENCY+1)-1:0] in_flight,
  output logic                        idle
);

  import cordic_pkg::*;

  localparam int CNT_W = $clog2(PIPE_LATENCY+1);

  logic               adv;
  logic               tail_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]   gnt_idx;
  logic               gnt_any;

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shadow_t          shadow_q [PIPE_LATENCY];
  shadow_t          shadow_d [PIPE_LATENCY];

  assign tail_valid = shadow_q[PIPE_LATENCY-1].valid;

  // A valid tail nobody takes freezes both pipes together
  assign adv = ~reset & ~(tail_valid & ~rsp_ready);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .en  (adv),
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    cordic_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) cordic_angle = req_angle[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (int'(gnt_idx) == NUM_REQ-1) ptr_d = '0;
      else ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (adv) begin
      shadow_d[0] = '{valid: gnt_any, tag: gnt_idx};
      for (int k = 1; k < PIPE_LATENCY; k++) begin
        shadow_d[k] = shadow_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      unique case ({gnt_any, tail_valid})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < PIPE_LATENCY; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign req_ready     = gnt;
  assign cordic_enable = adv;
  assign cordic_reset  = reset;
  assign rsp_valid     = tail_valid & ~reset;
  assign rsp_tag       = shadow_q[PIPE_LATENCY-1].tag;
  assign rsp_cos       = cordic_cos;
  assign in_flight     = cnt_q;
  assign idle          = (cnt_q == '0) & ~|req_valid;

endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// Randomized bench for the CORDIC cosine scheduler with a
// queue-based reference model and a behavioural CORDIC stand-in.
module tb_cordic_cos_scheduler;
  import cordic_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 22;
  localparam int LAT = 17;
  localparam int CW  = $clog2(LAT+1);

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_angle;
  logic [NR-1:0]     req_ready;
  logic              cordic_enable;
  logic              cordic_reset;
  logic [DW-1:0]     cordic_angle;
  logic [DW-1:0]     cordic_cos;
  logic              rsp_valid;
  logic [1:0]        rsp_tag;
  logic [DW-1:0]     rsp_cos;
  logic              rsp_ready;
  logic [CW-1:0]     in_flight;
  logic              idle;

  always #5 clk = ~clk;

  cordic_cos_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_angle     (req_angle),
    .req_ready     (req_ready),
    .cordic_enable (cordic_enable),
    .cordic_reset  (cordic_reset),
    .cordic_angle  (cordic_angle),
    .cordic_cos    (cordic_cos),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .rsp_cos       (rsp_cos),
    .rsp_ready     (rsp_ready),
    .in_flight     (in_flight),
    .idle          (idle)
  );

  // CORDIC stand-in: fixed-latency pipe with shared enable, truncated cos
  logic [DW-1:0] cpipe [LAT];
  int            c_int;

  always @(posedge clk) begin
    if (cordic_reset) begin
      for (int k = 0; k < LAT; k++) cpipe[k] <= '0;
    end else if (cordic_enable) begin
      cpipe[0] <= cordic_angle;
      for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
  end

  always_comb begin
    c_int = $rtoi($cos($itor($signed(cpipe[LAT-1])) / 1048576.0) * 1048576.0);
    cordic_cos = c_int[DW-1:0];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint obs,
                       input longint exp, input longint tol = 0);
    longint d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_chk++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic longint cos_q(input logic [DW-1:0] a);
    real r;
    r = $cos($itor($signed(a)) / 1048576.0) * 1048576.0;
    return longint'($rtoi($floor(r + 0.5)));
  endfunction

  function automatic logic [DW-1:0] rand_ang();
    int v;
    v = int'($urandom_range(3600000)) - 1800000;
    return v[DW-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: ordered list of issued ops, each aged by advancing edges
  typedef struct {
    int            tag;
    logic [DW-1:0] ang;
    int            age;
  } op_t;

  op_t q[$];
  int  ptr_m   = 0;
  bit  chk_on  = 0;
  int  rsp_cnt = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      bit            tail;
      bit            adv;
      int            gi;
      logic [NR-1:0] eg;
      logic [DW-1:0] ea;
      op_t           nop;
      tail = (q.size() > 0) && (q[0].age == LAT);
      adv  = !reset && !(tail && !rsp_ready);
      gi   = -1;
      if (adv) begin
        for (int k = 0; k < NR; k++) begin
          if (gi < 0 && req_valid[(ptr_m + k) % NR]) gi = (ptr_m + k) % NR;
        end
      end
      eg = '0;
      ea = '0;
      if (gi >= 0) begin
        eg[gi] = 1'b1;
        ea = req_angle[gi*DW +: DW];
      end
      check("rsp_valid", rsp_valid, tail && !reset);
      if (tail && !reset && rsp_valid) begin
        check("rsp_tag", rsp_tag, q[0].tag);
        check("rsp_cos", longint'($signed(rsp_cos)), cos_q(q[0].ang), 8);
        if (rsp_ready) rsp_cnt++;
      end
      check("cordic_enable", cordic_enable, adv);
      check("cordic_reset", cordic_reset, reset);
      check("req_ready", req_ready, eg);
      check("cordic_angle", cordic_angle, ea);
      check("in_flight", in_flight, q.size());
      check("idle", idle, (q.size() == 0) && (req_valid == '0));
      if (reset) begin
        q.delete();
        ptr_m = 0;
      end else if (adv) begin
        if (tail) void'(q.pop_front());
        foreach (q[k]) q[k].age++;
        if (gi >= 0) begin
          nop.tag = gi;
          nop.ang = ea;
          nop.age = 1;
          q.push_back(nop);
          ptr_m = (gi + 1) % NR;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((in_flight != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", in_flight, 0);
  endtask

  task automatic single_req(input int r, input logic [DW-1:0] a,
                            input longint expc);
    int            n;
    int            lat;
    bit            seen;
    logic [NR-1:0] ex;
    step();
    req_angle[r*DW +: DW] = a;
    req_valid = '0;
    req_valid[r] = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = req_ready[r];
    end
    ex = '0;
    ex[r] = 1'b1;
    check("single_grant", req_ready, ex);
    step();
    req_valid = '0;
    seen = 0;
    lat = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("single_ready_1cyc", req_ready, 0);
      seen = rsp_valid;
    end
    check("single_latency", lat, LAT);
    check("single_tag", rsp_tag, r);
    check("single_cos", longint'($signed(rsp_cos)), expc, 8);
  endtask

  initial begin
    int            prev_g;
    int            prev_t;
    int            g;
    int            last [NR];
    logic [1:0]    tag0;
    logic [DW-1:0] cos0;
    logic [NR-1:0] g_seen;
    int            base;

    reset     = 1'b1;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_idle", idle, 1);

    single_req(2, '0, 64'sd1048576);
    drain();

    // Full load, all requesters hold PI/4
    step();
    for (int i = 0; i < NR; i++) req_angle[i*DW +: DW] = PI_4;
    req_valid = '1;
    prev_g = -1;
    prev_t = -1;
    for (int i = 0; i < NR; i++) last[i] = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      g = onehot_idx(req_ready);
      check("full_onehot", $countones(req_ready), 1);
      if (prev_g >= 0) check("rr_order", g, (prev_g + 1) % NR);
      if (g >= 0) begin
        if (last[g] >= 0) check("no_starve", k - last[g], NR, 0);
        last[g] = k;
      end
      prev_g = g;
      if (k >= 18) check("full_in_flight", in_flight, LAT);
      if (rsp_valid) begin
        check("pi4_cos", longint'($signed(rsp_cos)), 64'sh0B504F, 8);
        if (prev_t >= 0) check("rsp_order", rsp_tag, (prev_t + 1) % NR);
        prev_t = int'(rsp_tag);
      end
    end

    // Backpressure with a full, valid tail
    step();
    rsp_ready = 1'b0;
    tag0 = '0;
    cos0 = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_enable", cordic_enable, 0);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      if (k == 0) begin
        tag0 = rsp_tag;
        cos0 = rsp_cos;
      end else begin
        check("bp_tag_stable", rsp_tag, tag0);
        check("bp_cos_stable", rsp_cos, cos0);
      end
    end
    step();
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    drain();

    // Reset with ten operations in flight
    step();
    req_valid = '1;
    repeat (10) @(negedge clk);
    step();
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("pre_rst_in_flight", in_flight, 10);
    step();
    reset = 1'b0;
    req_valid = '1;
    @(negedge clk);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_in_flight", in_flight, 0);
    check("post_rst_ptr0", req_ready, 4'b0001);
    drain();
    single_req(1, PI_4, 64'sh0B504F);
    drain();

    // Sparse requests, one every 3 cycles
    base = rsp_cnt;
    for (int k = 0; k < 20; k++) begin
      step();
      g = int'($urandom_range(NR - 1));
      req_angle[g*DW +: DW] = rand_ang();
      req_valid = '0;
      req_valid[g] = 1'b1;
      step();
      req_valid = '0;
      step();
    end
    drain();
    check("sparse_rsp_count", rsp_cnt - base, 20);

    // Random traffic with random backpressure
    g_seen = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_seen = req_ready;
      @(posedge clk);
      #1;
      rsp_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !g_seen[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(1));
          req_angle[i*DW +: DW] = rand_ang();
        end
      end
    end
    drain();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
